// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Single-issue instruction fetch stage with an IDLE/RUN/HALT controller.
//   Reads instruction memory combinationally at the PC, registers the fetched
//   word and its address for the decode stage, follows absolute short jumps,
//   honours downstream stalls and redirects, and stops after accepting 8'hFF.
//
// Ports
//   clk          clock, all state on rising edge
//   reset_n      synchronous active-low reset
//   start        pulse: IDLE -> RUN
//   imem_addr    instruction memory address (the PC)
//   imem_data    instruction at imem_addr, same-cycle read
//   out_valid    out_instr/out_pc hold a fetched instruction
//   out_ready    decode stage accepts when high with out_valid
//   out_instr    fetched instruction word
//   out_pc       address out_instr came from
//   redirect     flush request from downstream
//   redirect_pc  new PC on redirect
//   halted       high in HALT
//   fetch_count  accepted instructions, saturating at 8'hFF
module instr_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [2:0] JMP_OP   = 3'b011
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic [7:0] imem_addr,
   input  logic [7:0] imem_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_instr,
   output logic [7:0] out_pc,
   input  logic       redirect,
   input  logic [7:0] redirect_pc,
   output logic       halted,
   output logic [7:0] fetch_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_instr_q, out_instr_d;
   logic [7:0] out_pc_q, out_pc_d;
   logic [7:0] fetch_count_q, fetch_count_d;
   logic       handshake;

   assign handshake = out_valid_q & out_ready;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      // An accepted word leaves the register unless a new fetch refills it.
      out_valid_d   = out_valid_q & ~out_ready;
      out_instr_d   = out_instr_q;
      out_pc_d      = out_pc_q;
      fetch_count_d = fetch_count_q;

      if (handshake && (fetch_count_q != 8'hFF)) begin
         fetch_count_d = fetch_count_q + 8'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Priority: redirect, then halt acceptance, then fetch.
            if (redirect) begin
               pc_d        = redirect_pc;
               out_valid_d = 1'b0;
            end else if (handshake && (out_instr_q == 8'hFF)) begin
               state_d     = ST_HALT;
               out_valid_d = 1'b0;
            end else if (!out_valid_q || out_ready) begin
               out_valid_d = 1'b1;
               out_instr_d = imem_data;
               out_pc_d    = pc_q;
               if (imem_data[7:5] == JMP_OP) begin
                  pc_d = {3'b000, imem_data[4:0]};
               end else begin
                  pc_d = pc_q + 8'd1;
               end
            end
         end
         ST_HALT: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         out_valid_q   <= 1'b0;
         out_instr_q   <= '0;
         out_pc_q      <= '0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_pc_q      <= out_pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_addr   = pc_q;
   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_pc      = out_pc_q;
   assign fetch_count = fetch_count_q;
   assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed scenarios for the fetch unit followed by a randomized run
//   compared every cycle against a transaction-level reference model.
module tb_instr_fetch_unit;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_instr;
   logic [7:0] out_pc;
   logic       redirect;
   logic [7:0] redirect_pc;
   logic       halted;
   logic [7:0] fetch_count;

   logic [7:0] mem [256];

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 = idle, 1 = running, 2 = halted.
   int         m_mode;
   logic [7:0] m_pc, m_instr, m_opc, m_cnt;
   logic       m_valid;

   instr_fetch_unit #(.RESET_PC(8'h00), .JMP_OP(3'b011)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .halted(halted), .fetch_count(fetch_count)
   );

   assign imem_data = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock: evaluate the model with the inputs now applied,
   // take the edge, then settle 1 time unit past it.
   task automatic step();
      int         n_mode, n_pc, n_cnt;
      logic [7:0] n_instr, n_opc, w;
      logic       n_valid;
      bit         accepted;
      n_mode   = m_mode;
      n_pc     = int'(m_pc);
      n_cnt    = int'(m_cnt);
      n_instr  = m_instr;
      n_opc    = m_opc;
      accepted = m_valid && out_ready;
      n_valid  = m_valid && !out_ready;
      if (!reset_n) begin
         n_mode = 0; n_pc = 0; n_valid = 1'b0;
         n_instr = 8'h00; n_opc = 8'h00; n_cnt = 0;
      end else begin
         if (accepted && n_cnt < 255) n_cnt = n_cnt + 1;
         if (m_mode == 0) begin
            if (start) n_mode = 1;
         end else if (m_mode == 1) begin
            if (redirect) begin
               n_pc = int'(redirect_pc);
               n_valid = 1'b0;
            end else if (accepted && m_instr == 8'hFF) begin
               n_mode = 2;
               n_valid = 1'b0;
            end else if (!m_valid || out_ready) begin
               w = mem[m_pc];
               n_instr = w;
               n_opc = m_pc;
               n_valid = 1'b1;
               if ((int'(w) / 32) == 3) n_pc = int'(w) % 32;
               else n_pc = (int'(m_pc) + 1) % 256;
            end
         end
      end
      @(posedge clk);
      m_mode  = n_mode;
      m_pc    = n_pc[7:0];
      m_cnt   = n_cnt[7:0];
      m_instr = n_instr;
      m_opc   = n_opc;
      m_valid = n_valid;
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start = 1'b0; redirect = 1'b0;
      redirect_pc = 8'h00; out_ready = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic fill_seq();
      for (int unsigned i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
   endtask

   task automatic test_reset();
      fill_seq();
      start = 1'b1; redirect = 1'b1; redirect_pc = 8'h55; out_ready = 1'b1;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1; start = 1'b0; redirect = 1'b0;
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 8'h00); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (out_instr !== 8'h00) begin errors++; $display("FAIL reset_instr got %h exp 00", out_instr); end
      checks++; if (out_pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", out_pc); end
      checks++; if (fetch_count !== 8'h00) begin errors++; $display("FAIL reset_count got %h exp 00", fetch_count); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
   endtask

   task automatic test_sequential();
      logic [7:0] exp_i [4];
      exp_i[0] = 8'h49; exp_i[1] = 8'h38; exp_i[2] = 8'h98; exp_i[3] = 8'hA2;
      fill_seq();
      for (int i = 0; i < 4; i++) mem[i] = exp_i[i];
      do_reset();
      do_start();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (out_valid !== 1'b1 || out_pc !== 8'(i) || out_instr !== exp_i[i]) begin
            errors++; $display("FAIL seq_%0d got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", i, out_valid, out_pc, out_instr, 8'(i), exp_i[i]);
         end
      end
      step();
      checks++; if (fetch_count !== 8'd4) begin errors++; $display("FAIL seq_count got %0d exp 4", fetch_count); end
   endtask

   task automatic test_jump();
      logic [7:0] exp_pc [6];
      logic [7:0] exp_in [6];
      fill_seq();
      mem[4] = 8'h67; mem[7] = 8'h5A;
      exp_pc[0] = 8'd0; exp_pc[1] = 8'd1; exp_pc[2] = 8'd2;
      exp_pc[3] = 8'd3; exp_pc[4] = 8'd4; exp_pc[5] = 8'd7;
      exp_in[0] = 8'h10; exp_in[1] = 8'h11; exp_in[2] = 8'h12;
      exp_in[3] = 8'h13; exp_in[4] = 8'h67; exp_in[5] = 8'h5A;
      do_reset();
      do_start();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== exp_in[i]) begin
            errors++; $display("FAIL jump_%0d got pc=%h i=%h exp pc=%h i=%h", i, out_pc, out_instr, exp_pc[i], exp_in[i]);
         end
      end
   endtask

   task automatic test_stall();
      fill_seq();
      do_reset();
      do_start();
      out_ready = 1'b1;
      step(); step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (out_valid !== 1'b1 || out_pc !== 8'h01 || out_instr !== 8'h11 || imem_addr !== 8'h02) begin
            errors++; $display("FAIL stall_%0d got v=%b pc=%h i=%h a=%h exp v=1 pc=01 i=11 a=02", i, out_valid, out_pc, out_instr, imem_addr);
         end
      end
      out_ready = 1'b1;
      for (int i = 2; i < 5; i++) begin
         step();
         checks++; if (out_valid !== 1'b1 || out_pc !== 8'(i) || out_instr !== 8'(8'h10 + i)) begin
            errors++; $display("FAIL resume_%0d got pc=%h i=%h exp pc=%h i=%h", i, out_pc, out_instr, 8'(i), 8'(8'h10 + i));
         end
      end
      checks++; if (fetch_count !== 8'd4) begin errors++; $display("FAIL stall_count got %0d exp 4", fetch_count); end
   endtask

   task automatic test_redirect();
      fill_seq();
      mem[2] = 8'h65; mem[8'h20] = 8'h44;
      do_reset();
      do_start();
      out_ready = 1'b1;
      step(); step();
      redirect = 1'b1; redirect_pc = 8'h20;
      step();
      redirect = 1'b0;
      checks++; if (out_valid !== 1'b0 || imem_addr !== 8'h20) begin
         errors++; $display("FAIL redir_flush got v=%b a=%h exp v=0 a=20", out_valid, imem_addr);
      end
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'h20 || out_instr !== 8'h44) begin
         errors++; $display("FAIL redir_target got v=%b pc=%h i=%h exp v=1 pc=20 i=44", out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_halt();
      fill_seq();
      mem[2] = 8'hFF;
      do_reset();
      do_start();
      out_ready = 1'b1;
      step(); step(); step();
      checks++; if (out_pc !== 8'h02 || out_instr !== 8'hFF || halted !== 1'b0) begin
         errors++; $display("FAIL halt_word got pc=%h i=%h h=%b exp pc=02 i=ff h=0", out_pc, out_instr, halted);
      end
      step();
      checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 8'd3) begin
         errors++; $display("FAIL halt_enter got h=%b v=%b c=%0d exp h=1 v=0 c=3", halted, out_valid, fetch_count);
      end
      start = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
      step(); step();
      start = 1'b0; redirect = 1'b0;
      step();
      checks++; if (halted !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 8'h03 || fetch_count !== 8'd3) begin
         errors++; $display("FAIL halt_hold got h=%b v=%b a=%h c=%0d exp h=1 v=0 a=03 c=3", halted, out_valid, imem_addr, fetch_count);
      end
   endtask

   task automatic test_wrap();
      fill_seq();
      mem[8'hFF] = 8'h12; mem[0] = 8'h34;
      do_reset();
      do_start();
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFF;
      step();
      redirect = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'hFF || out_instr !== 8'h12) begin
         errors++; $display("FAIL wrap_ff got v=%b pc=%h i=%h exp v=1 pc=ff i=12", out_valid, out_pc, out_instr);
      end
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 8'h34) begin
         errors++; $display("FAIL wrap_00 got v=%b pc=%h i=%h exp v=1 pc=00 i=34", out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_reset_mid_stall();
      fill_seq();
      do_reset();
      do_start();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      out_ready = 1'b0;
      step(); step();
      checks++; if (fetch_count !== 8'd5 || out_valid !== 1'b1) begin
         errors++; $display("FAIL pre_reset got c=%0d v=%b exp c=5 v=1", fetch_count, out_valid);
      end
      reset_n = 1'b0; redirect = 1'b1; redirect_pc = 8'h33;
      step();
      reset_n = 1'b1; redirect = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_instr !== 8'h00 || out_pc !== 8'h00 || fetch_count !== 8'h00 || halted !== 1'b0 || imem_addr !== 8'h00) begin
         errors++; $display("FAIL mid_reset got v=%b i=%h pc=%h c=%h h=%b a=%h exp all zero", out_valid, out_instr, out_pc, fetch_count, halted, imem_addr);
      end
      out_ready = 1'b1;
      step(); step(); step();
      checks++; if (out_valid !== 1'b0 || imem_addr !== 8'h00 || fetch_count !== 8'h00) begin
         errors++; $display("FAIL idle_hold got v=%b a=%h c=%h exp v=0 a=00 c=00", out_valid, imem_addr, fetch_count);
      end
   endtask

   task automatic test_random();
      for (int unsigned i = 0; i < 256; i++) mem[i] = 8'($urandom);
      do_reset();
      for (int n = 0; n < 600; n++) begin
         reset_n     = ($urandom_range(0, 49) != 0);
         start       = ($urandom_range(0, 5) == 0);
         out_ready   = ($urandom_range(0, 2) != 0);
         redirect    = ($urandom_range(0, 11) == 0);
         redirect_pc = 8'($urandom);
         if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 255)] = 8'($urandom);
         step();
         checks++; if (imem_addr !== m_pc || out_valid !== m_valid || out_instr !== m_instr || out_pc !== m_opc || fetch_count !== m_cnt || halted !== (m_mode == 2)) begin
            errors++;
            $display("FAIL rand_%0d got a=%h v=%b i=%h pc=%h c=%h h=%b exp a=%h v=%b i=%h pc=%h c=%h h=%b",
                     n, imem_addr, out_valid, out_instr, out_pc, fetch_count, halted,
                     m_pc, m_valid, m_instr, m_opc, m_cnt, (m_mode == 2));
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      redirect = 1'b0; redirect_pc = 8'h00;
      m_mode = 0; m_pc = '0; m_instr = '0; m_opc = '0; m_cnt = '0; m_valid = 1'b0;
      #2;
      test_reset();
      test_sequential();
      test_jump();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_reset_mid_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
